// File: rtl/noc_local_inject_arb.sv
// Packet-granular round-robin arbiter feeding a router LOCAL input port through one output register.
// Optional per-requester packet counters are enabled by defining NOC_INJ_PKT_CNT_EN.
module noc_local_inject_arb #(
    parameter  int unsigned FLIT_WIDTH = 32,
    parameter  int unsigned CHANNELS   = 2,
    parameter  int unsigned REQS       = 3,
    localparam int unsigned VCW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned RIW        = $clog2(REQS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQS*FLIT_WIDTH-1:0] req_flit,
    input  logic [REQS-1:0]            req_last,
    input  logic [REQS*VCW-1:0]        req_vc,
    input  logic [REQS-1:0]            req_valid,
    output logic [REQS-1:0]            req_ready,
    output logic [FLIT_WIDTH-1:0]      out_flit,
    output logic                       out_last,
    output logic [CHANNELS-1:0]        out_valid,
    input  logic [CHANNELS-1:0]        out_ready,
    output logic                       busy,
    output logic [RIW-1:0]             grant_id
`ifdef NOC_INJ_PKT_CNT_EN
    ,
    output logic [REQS*16-1:0]         pkt_cnt,
    input  logic                       cnt_clr
`endif
);

    typedef enum logic {S_IDLE, S_LOCK} state_e;

    state_e                  state_q;
    logic [RIW-1:0]          grant_q;
    logic [RIW-1:0]          rr_ptr_q;
    logic [VCW-1:0]          vc_q;
    logic [FLIT_WIDTH-1:0]   out_flit_q;
    logic                    out_last_q;
    logic [CHANNELS-1:0]     out_valid_q;

    logic [FLIT_WIDTH-1:0]   flit_a [REQS];
    logic [VCW-1:0]          vc_a   [REQS];
    logic [RIW-1:0]          winner;
    logic                    found;
    logic [RIW-1:0]          sel;
    logic [VCW-1:0]          vc_sel;
    logic                    slot_free;
    logic                    accept;
    logic                    acc_last;

    for (genvar g = 0; g < REQS; g++) begin : g_unpack
        assign flit_a[g] = req_flit[g*FLIT_WIDTH +: FLIT_WIDTH];
        assign vc_a[g]   = req_vc[g*VCW +: VCW];
    end

    function automatic logic [RIW-1:0] inc_ptr(input logic [RIW-1:0] p);
        return (32'(p) == REQS - 1) ? '0 : p + RIW'(1);
    endfunction

    // Register is free when empty or when its held flit drains this cycle on its own VC.
    assign slot_free = ~(|out_valid_q) | (|(out_valid_q & out_ready));

    // Circular search for the first valid requester at or after rr_ptr.
    always_comb begin : p_search
        int unsigned k;
        k      = 0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < REQS; i++) begin
            k = 32'(rr_ptr_q) + i;
            if (k >= REQS) k = k - REQS;
            if (!found && req_valid[RIW'(k)]) begin
                found  = 1'b1;
                winner = RIW'(k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel       = grant_q;
        vc_sel    = vc_q;
        if (state_q == S_IDLE) begin
            sel    = winner;
            vc_sel = vc_a[winner];
            if (found && slot_free) req_ready[winner] = 1'b1;
        end else begin
            req_ready[grant_q] = slot_free;
        end
    end

    assign accept   = |(req_ready & req_valid);
    assign acc_last = req_last[sel];

    // Arbitration FSM and output register; req_vc only matters on the first flit of a packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            vc_q        <= '0;
            out_flit_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= '0;
        end else begin
            if (accept) begin
                out_flit_q  <= flit_a[sel];
                out_last_q  <= acc_last;
                out_valid_q <= CHANNELS'(1) << vc_sel;
            end else if (slot_free) begin
                out_valid_q <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        grant_q <= winner;
                        vc_q    <= vc_sel;
                        if (acc_last) rr_ptr_q <= inc_ptr(winner);
                        else          state_q  <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (accept && acc_last) begin
                        state_q  <= S_IDLE;
                        rr_ptr_q <= inc_ptr(grant_q);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_flit  = out_flit_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == S_LOCK) | (|out_valid_q);

`ifdef NOC_INJ_PKT_CNT_EN
    logic [15:0] cnt_q [REQS];

    // Saturating per-requester count of accepted last flits; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int i = 0; i < REQS; i++) cnt_q[i] <= '0;
        end else if (accept && acc_last && (cnt_q[sel] != 16'hFFFF)) begin
            cnt_q[sel] <= cnt_q[sel] + 16'd1;
        end
    end

    for (genvar g = 0; g < REQS; g++) begin : g_cnt
        assign pkt_cnt[g*16 +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_noc_local_inject_arb.sv
// Directed bench for noc_local_inject_arb: per-requester flit sources, transfer monitor, hand-derived expectations.
module tb_noc_local_inject_arb;
    localparam int unsigned FW = 32;
    localparam int unsigned CH = 2;
    localparam int unsigned RQ = 3;

    typedef struct packed { logic [1:0] r; logic vc; logic last; logic [31:0] flit; } src_t;
    typedef struct packed { logic [31:0] cyc; logic [31:0] flit; logic last; logic [1:0] ov; } obs_t;
    typedef struct packed { logic [31:0] cyc; logic [1:0] r; } acc_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [RQ*FW-1:0] req_flit = '0;
    logic [RQ-1:0]    req_last = '0;
    logic [RQ-1:0]    req_vc = '0;
    logic [RQ-1:0]    req_valid = '0;
    logic [RQ-1:0]    req_ready;
    logic [FW-1:0]    out_flit;
    logic             out_last;
    logic [CH-1:0]    out_valid;
    logic [CH-1:0]    out_ready = 2'b11;
    logic             busy;
    logic [1:0]       grant_id;
`ifdef NOC_INJ_PKT_CNT_EN
    logic [RQ*16-1:0] pkt_cnt;
    logic             cnt_clr = 1'b0;
`endif

    src_t pend[$];
    obs_t obs[$];
    acc_t accq[$];
    logic [RQ-1:0] en = '1;
    logic [RQ-1:0] acc_s = '0;
    int   cyc = 0;
    int   busy_fall = -1;
    logic busy_prev = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    noc_local_inject_arb #(.FLIT_WIDTH(FW), .CHANNELS(CH), .REQS(RQ)) dut (
        .clk(clk), .rst(rst),
        .req_flit(req_flit), .req_last(req_last), .req_vc(req_vc),
        .req_valid(req_valid), .req_ready(req_ready),
        .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .grant_id(grant_id)
`ifdef NOC_INJ_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt), .cnt_clr(cnt_clr)
`endif
    );

    function automatic int first_idx(input int r);
        for (int i = 0; i < pend.size(); i++)
            if (int'(pend[i].r) == r) return i;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Sources: pop accepted heads at the edge, then present the next head slightly after it.
    always @(posedge clk) begin
        int idx;
        for (int r = 0; r < RQ; r++) begin
            idx = first_idx(r);
            if (acc_s[r] && idx >= 0) pend.delete(idx);
        end
        #1;
        for (int r = 0; r < RQ; r++) begin
            idx = first_idx(r);
            if (idx >= 0 && en[r]) begin
                req_valid[r]         = 1'b1;
                req_flit[r*FW +: FW] = pend[idx].flit;
                req_last[r]          = pend[idx].last;
                req_vc[r]            = pend[idx].vc;
            end else begin
                req_valid[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        obs_t o;
        acc_t a;
        acc_s = req_valid & req_ready;
        for (int r = 0; r < RQ; r++)
            if (acc_s[r]) begin
                a.cyc = 32'(cyc); a.r = 2'(r);
                accq.push_back(a);
            end
        if (|(out_valid & out_ready)) begin
            o.cyc = 32'(cyc); o.flit = out_flit; o.last = out_last; o.ov = out_valid;
            obs.push_back(o);
        end
        if (busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int r, input logic vc, input logic last, input logic [31:0] flit);
        src_t s;
        s.r = 2'(r); s.vc = vc; s.last = last; s.flit = flit;
        pend.push_back(s);
    endtask

    task automatic wait_obs(input int n, input int budget, input string tag);
        int t = 0;
        while (obs.size() < n && t < budget) begin tick(); t++; end
        check(tag, 32'(obs.size()), 32'(n));
    endtask

    task automatic wait_acc(input int n, input int budget, input string tag);
        int t = 0;
        while (accq.size() < n && t < budget) begin tick(); t++; end
        check(tag, 32'(accq.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_flit;
        int          rd, rr, jj;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_flit", out_flit, 32'h0);
        check("rst_out_last", 32'(out_last), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;

        // Single requester, 4-flit packet on VC1
        obs.delete(); accq.delete(); busy_fall = -1;
        for (int j = 0; j < 4; j++) push(0, 1'b1, j == 3, 32'hA0 + 32'(j));
        wait_obs(4, 50, "t1_count");
        repeat (2) tick();
        for (int j = 0; j < 4; j++) begin
            check("t1_flit", obs[j].flit, 32'hA0 + 32'(j));
            check("t1_last", 32'(obs[j].last), (j == 3) ? 32'h1 : 32'h0);
            check("t1_vc", 32'(obs[j].ov), 32'h2);
            check("t1_cycle", obs[j].cyc, accq[0].cyc + 32'(1 + j));
        end
        check("t1_busy_drop", 32'(busy_fall), obs[3].cyc + 32'h1);
        check("t1_grant_id", 32'(grant_id), 32'h0);

        // Contention: three 3-flit packets per round, two rounds, rr_ptr from reset
        rst = 1'b1; tick(); rst = 1'b0;
        obs.delete(); accq.delete();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 3; r++)
                for (int j = 0; j < 3; j++)
                    push(r, r == 1, j == 2, 32'hC000_0000 | 32'(d << 8) | 32'(r << 4) | 32'(j));
        wait_obs(18, 100, "t2_count");
        for (int i = 0; i < 18; i++) begin
            rd = i / 9; rr = (i / 3) % 3; jj = i % 3;
            exp_flit = 32'hC000_0000 | 32'(rd << 8) | 32'(rr << 4) | 32'(jj);
            check("t2_flit", obs[i].flit, exp_flit);
            check("t2_last", 32'(obs[i].last), (jj == 2) ? 32'h1 : 32'h0);
            check("t2_vc", 32'(obs[i].ov), (rr == 1) ? 32'h2 : 32'h1);
            check("t2_no_gap", obs[i].cyc, obs[0].cyc + 32'(i));
        end

        // Backpressure on locked VC0 while VC1 stays ready
        obs.delete(); accq.delete();
        for (int j = 0; j < 6; j++) push(0, 1'b0, j == 5, 32'h300 + 32'(j));
        wait_acc(2, 50, "t3_start");
        out_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_hold_flit", out_flit, 32'h301);
            check("t3_hold_valid", 32'(out_valid), 32'h1);
            check("t3_hold_ready", 32'(req_ready), 32'h0);
            tick();
        end
        out_ready = 2'b11;
        wait_obs(6, 50, "t3_count");
        for (int j = 0; j < 6; j++) check("t3_flit", obs[j].flit, 32'h300 + 32'(j));
        repeat (3) tick();
        check("t3_no_dup", 32'(obs.size()), 32'd6);

        // Mid-packet bubble on requester 1 while requester 0 waits
        obs.delete(); accq.delete();
        for (int j = 0; j < 4; j++) push(1, 1'b1, j == 3, 32'h400 + 32'(j));
        for (int j = 0; j < 2; j++) push(0, 1'b0, j == 1, 32'h410 + 32'(j));
        wait_acc(2, 50, "t4_start");
        en[1] = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_bubble_ready", 32'(req_ready), 32'h2);
            check("t4_bubble_busy", 32'(busy), 32'h1);
            if (i > 0) check("t4_bubble_valid", 32'(out_valid), 32'h0);
            if (i == 2) en[1] = 1'b1;
            tick();
        end
        wait_obs(6, 50, "t4_count");
        for (int j = 0; j < 6; j++) begin
            check("t4_flit", obs[j].flit, (j < 4) ? 32'h400 + 32'(j) : 32'h410 + 32'(j - 4));
            check("t4_acc_order", 32'(accq[j].r), (j < 4) ? 32'h1 : 32'h0);
        end

        // Reset during the third flit of a 4-flit packet
        obs.delete(); accq.delete();
        for (int j = 0; j < 4; j++) push(2, 1'b0, j == 3, 32'h500 + 32'(j));
        wait_acc(2, 50, "t5_start");
        out_ready = 2'b10;
        rst = 1'b1;
        pend.delete();
        tick();
        rst = 1'b0;
        out_ready = 2'b11;
        #1;
        check("t5_out_valid", 32'(out_valid), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_grant_id", 32'(grant_id), 32'h0);
        check("t5_out_last", 32'(out_last), 32'h0);
        for (int j = 0; j < 2; j++) push(1, 1'b1, j == 1, 32'h600 + 32'(j));
        wait_obs(3, 50, "t5_count");
        check("t5_flit0", obs[0].flit, 32'h500);
        check("t5_flit1", obs[1].flit, 32'h600);
        check("t5_flit2", obs[2].flit, 32'h601);
        check("t5_last2", 32'(obs[2].last), 32'h1);
        check("t5_vc1", 32'(obs[1].ov), 32'h2);
        repeat (2) tick();
        check("t5_no_extra", 32'(obs.size()), 32'd3);
        check("t5_grant_new", 32'(grant_id), 32'h1);

`ifdef NOC_INJ_PKT_CNT_EN
        // Packet counters: three single-flit packets, then clear coinciding with a last flit
        rst = 1'b1; tick(); rst = 1'b0;
        obs.delete(); accq.delete();
        for (int k = 0; k < 3; k++) push(2, 1'b0, 1'b1, 32'h700 + 32'(k));
        wait_obs(3, 50, "cnt_count");
        tick();
        check("cnt_req2", 32'(pkt_cnt[32 +: 16]), 32'd3);
        check("cnt_req0", 32'(pkt_cnt[0 +: 16]), 32'd0);
        accq.delete();
        for (int j = 0; j < 2; j++) push(2, 1'b0, j == 1, 32'h710 + 32'(j));
        wait_acc(1, 50, "cnt_clr_start");
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_clr_accepts", 32'(accq.size()), 32'd2);
        check("cnt_clr_req2", 32'(pkt_cnt[32 +: 16]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/noc_local_inject_arb.md
Name: noc_local_inject_arb

Overview:
Packet-granular round-robin arbiter in front of a mesh router's LOCAL input port. Shares one router injection port between REQS tile-side requesters (for example core LSU, DMA and config master). Each requester selects its own virtual channel. Output is fully registered, so the router's combinational input path is decoupled from the tile. Once a packet starts, the grant is held until its last flit is accepted, so flits of different packets never interleave on a VC.

Parameters:
FLIT_WIDTH, 32, flit width in bits
CHANNELS, 2, number of virtual channels on the router port
REQS, 3, number of requesters, 2..8
VCW, derived: CHANNELS>1 ? $clog2(CHANNELS) : 1, VC index width
RIW, derived: $clog2(REQS), requester index width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_flit  in  REQS*FLIT_WIDTH  flit per requester
req_last  in  REQS  last flit of packet
req_vc  in  REQS*VCW  target VC, sampled on the packet's first flit
req_valid  in  REQS  flit valid
req_ready  out  REQS  flit accepted when valid&ready
out_flit  out  FLIT_WIDTH  to router local in_flit
out_last  out  1  to router local in_last
out_valid  out  CHANNELS  one-hot valid on the locked VC
out_ready  in  CHANNELS  router local in_ready
busy  out  1  packet lock held or output register occupied
grant_id  out  RIW  current or last granted requester

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: out_valid=0, out_flit=0, out_last=0, busy=0, grant_id=0, rr_ptr=0, state=IDLE, req_ready=0.
- Output register slot: "free" = !(|out_valid) | out_ready[vc_q]. A transfer to the router happens when out_valid[vc_q] & out_ready[vc_q]. out_ready on other VCs is ignored.
- FSM IDLE:
  - Pick the first valid requester at or after rr_ptr (circular search).
  - If one exists and the slot is free: grant_q=winner, vc_q=req_vc[winner], req_ready[winner]=1 in the same cycle (combinational from req_valid), load flit.
  - If that flit has req_last=1, stay IDLE (single-flit packet) and set rr_ptr=winner+1 mod REQS. Otherwise go to LOCK.
- FSM LOCK:
  - req_ready[grant_q]=slot free. All other req_ready=0.
  - Each accepted flit is loaded into the output register with vc_q.
  - When an accepted flit has last=1: go to IDLE, set rr_ptr=grant_q+1 mod REQS.
  - req_vc is ignored while in LOCK.
- Latency: flit accepted in cycle N appears on out_* in cycle N+1. Throughput is 1 flit/cycle while out_ready[vc_q]=1.
- Back-to-back packets: a new grant may issue in the same cycle that the previous last flit drains from the output register (slot free).
- Packet boundary: the output register may hold the last flit of packet A (VC a) while packet B (VC b) is granted. B's first flit loads only when the slot is free, so at most one flit is ever held.
- Fairness: after packet end, the finishing requester has lowest priority. The worst-case wait for any requester is REQS-1 packets.
- A requester that deasserts req_valid mid-packet keeps the lock. There is no timeout, and bubbles pass through with out_valid=0.
- Reset mid-packet discards the held flit and the lock immediately. The router sees no further flits of that packet.
- grant_id reflects grant_q and updates on each new grant.
- busy = (state==LOCK) | (|out_valid).

Optional Feature:
NOC_INJ_PKT_CNT_EN:
- Defined: adds port pkt_cnt out REQS*16 and port cnt_clr in 1.
- Per-requester 16-bit saturating counter (stops at 0xFFFF) increments when that requester's last flit is accepted.
- cnt_clr=1 zeroes all counters that cycle and has priority over increment. rst also zeroes them.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Single requester: req0 sends 4-flit packet 0xA0..0xA3 on VC1, out_ready=2'b11 -> out_valid=2'b10 for 4 consecutive cycles starting 1 cycle after the first accept, out_last only on 0xA3, busy drops 1 cycle after 0xA3 transfers.
- Contention: req0/1/2 each hold valid 3-flit packets, rr_ptr=0 -> packets emitted in order 0,1,2 with no interleaving and no idle cycle between packets. Repeated round keeps order 0,1,2.
- Backpressure on locked VC: VC0 packet, out_ready[0]=0 for 5 cycles mid-packet while out_ready[1]=1 -> out_flit held stable, req_ready=0, no flit lost or duplicated.
- Mid-packet bubble: req1 drops valid for 3 cycles inside a packet while req0 is valid -> req0 gets no ready until req1's last flit is accepted.
- Reset mid-packet: rst asserted for 1 cycle during flit 2 of 4 -> next cycle out_valid=0, busy=0, grant_id=0, IDLE. A fresh packet is then accepted normally.
- With NOC_INJ_PKT_CNT_EN: 3 packets from req2 -> pkt_cnt[2]=3. Then cnt_clr pulsed in the same cycle as a req2 last flit -> pkt_cnt[2]=0.
